led_scanner: RTL and testbench

LED_SCANNER -- requirements
Module: led_scanner

---
 rtl/led_scanner.sv | 150 +++++++++++++++
 tb/tb_led_scanner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/led_scanner.sv
// Bouncing LED scanner: one lit position sweeps 0..7..0 with a two-step
// fading trail, brightness produced by a free-running PWM counter.
module led_scanner #(
  parameter int STEP_DIV = 1200000,
  parameter int PWM_BITS = 4
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic EN,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  // A prescaler of at least one bit keeps STEP_DIV=1 legal.
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PW-1:0]       presc;
  logic                tick;
  dir_t                dir, dir_nxt;
  logic [2:0]          pos, pos_nxt;
  logic [2:0]          tr1, tr2;
  logic [7:0]          led_nxt;
  logic [7:0]          led_p0;

  // Half brightness: lit during the lower half of the PWM period.
  function automatic logic half_on(input logic [PWM_BITS-1:0] cnt);
    return ~cnt[PWM_BITS-1];
  endfunction

  // Quarter brightness: lit during the first quarter of the PWM period.
  function automatic logic quarter_on(input logic [PWM_BITS-1:0] cnt);
    return (cnt[PWM_BITS-1:PWM_BITS-2] == 2'b00);
  endfunction

  // A step is taken only while enabled and the prescaler is at its last count.
  assign tick = EN && (presc == PRESC_MAX);

  // Free-running PWM counter; keeps running while paused.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Step prescaler; frozen while EN is low.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      presc <= '0;
    end else if (EN) begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Direction state, position and trail advance together on each tick.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      dir <= UP;
      pos <= 3'd0;
      tr1 <= 3'd0;
      tr2 <= 3'd0;
    end else if (tick) begin
      dir <= dir_nxt;
      pos <= pos_nxt;
      tr1 <= pos;
      tr2 <= tr1;
    end
  end

  // Bounce rule: turn around at the ends so each end is held for one step.
  always_comb begin
    dir_nxt = dir;
    pos_nxt = pos;
    case (dir)
      UP: begin
        if (pos == 3'd7) begin
          dir_nxt = DOWN;
          pos_nxt = 3'd6;
        end else begin
          pos_nxt = pos + 3'd1;
        end
      end
      DOWN: begin
        if (pos == 3'd0) begin
          dir_nxt = UP;
          pos_nxt = 3'd1;
        end else begin
          pos_nxt = pos - 3'd1;
        end
      end
      default: begin
        dir_nxt = UP;
        pos_nxt = 3'd0;
      end
    endcase
  end

  // Per-LED brightness; the brightest matching source wins on overlap.
  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) == pos) begin
        led_nxt[i] = 1'b1;
      end else if (3'(i) == tr1) begin
        led_nxt[i] = half_on(pwm_cnt);
      end else if (3'(i) == tr2) begin
        led_nxt[i] = quarter_on(pwm_cnt);
      end else begin
        led_nxt[i] = 1'b0;
      end
    end
  end

  // Output register stage so the LED pins are glitch-free.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      led_p0 <= '0;
    end else begin
      led_p0 <= led_nxt;
    end
  end

  assign LED0 = led_p0[0];
  assign LED1 = led_p0[1];
  assign LED2 = led_p0[2];
  assign LED3 = led_p0[3];
  assign LED4 = led_p0[4];
  assign LED5 = led_p0[5];
  assign LED6 = led_p0[6];
  assign LED7 = led_p0[7];

endmodule

// File: tb/tb_led_scanner.sv
// Scoreboard bench for led_scanner: a closed-form bounce model predicts the
// LED vector for every clock; a monitor compares on the opposite edge.
module tb_led_scanner;

  localparam int STEP_DIV = 4;
  localparam int PWM_BITS = 4;
  localparam int PWM_MOD  = 1 << PWM_BITS;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic EN = 1'b0;
  logic LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic [7:0] leds;

  int tests = 0;
  int fails = 0;

  // Model state: ticks taken since reset, prescaler and PWM phase.
  int m_k = 0;
  int m_presc = 0;
  int m_pwm = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  int cnt[8];

  led_scanner #(.STEP_DIV(STEP_DIV), .PWM_BITS(PWM_BITS)) dut (
    .CLK(CLK), .RSTN(RSTN), .EN(EN),
    .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3),
    .LED4(LED4), .LED5(LED5), .LED6(LED6), .LED7(LED7)
  );

  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  always #5 CLK = ~CLK;

  // Position after k ticks: a triangle wave of period 14 over 0..7.
  function automatic int pos_at(input int k);
    int r;
    if (k < 0) return 0;
    r = k % 14;
    return (r <= 7) ? r : 14 - r;
  endfunction

  // LED vector for a given tick count and PWM phase; later writes win.
  function automatic logic [7:0] exp_leds(input int k, input int pwm);
    logic [7:0] v;
    v = '0;
    v[pos_at(k - 2)] = (pwm < PWM_MOD / 4);
    v[pos_at(k - 1)] = (pwm < PWM_MOD / 2);
    v[pos_at(k)] = 1'b1;
    return v;
  endfunction

  // Reference model: push the expected output for this edge, then advance.
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_k = 0;
      m_presc = 0;
      m_pwm = 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(exp_leds(m_k, m_pwm));
      if (EN) begin
        if (m_presc == STEP_DIV - 1) begin
          m_presc = 0;
          m_k++;
        end else begin
          m_presc++;
        end
      end
      m_pwm = (m_pwm + 1) % PWM_MOD;
    end
  end

  // Monitor: compare DUT LEDs against the queued prediction.
  always @(negedge CLK) begin
    if (RSTN && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tests++;
      if (leds !== exp_v) begin
        fails++;
        $display("FAIL led_sb t=%0t: got %b expected %b", $time, leds, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_k(input int k);
    for (int i = 0; i < 1000 && m_k != k; i++) @(negedge CLK);
    if (m_k != k) check("wait_tick_count", m_k, k);
  endtask

  task automatic count16();
    for (int j = 0; j < 8; j++) cnt[j] = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      for (int j = 0; j < 8; j++) cnt[j] += int'(leds[j]);
    end
  endtask

  task automatic async_pulse();
    #2 RSTN = 1'b0;
    #1 check("async_reset_leds", leds, 0);
    #1 RSTN = 1'b1;
  endtask

  // Directed phases followed by randomized enable and reset traffic.
  initial begin
    RSTN = 1'b0;
    EN = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_leds", leds, 0);

    // Idle after release: LED0 only, steady.
    RSTN = 1'b1;
    repeat (100) @(negedge CLK);
    check("idle_leds", leds, 1);

    // Restart with EN high from release.
    RSTN = 1'b0;
    #1 check("reset_again_leds", leds, 0);
    @(negedge CLK);
    RSTN = 1'b1;
    EN = 1'b1;

    // Trail duty at pos=2, tr1=1, tr2=0.
    wait_k(2);
    EN = 1'b0;
    @(negedge CLK);
    count16();
    check("duty_led2", cnt[2], 16);
    check("duty_led1", cnt[1], 8);
    check("duty_led0", cnt[0], 4);
    check("duty_others", cnt[3] + cnt[4] + cnt[5] + cnt[6] + cnt[7], 0);

    // Bounce 7->6: LED6 full beats tr2, LED7 at half.
    EN = 1'b1;
    wait_k(8);
    EN = 1'b0;
    @(negedge CLK);
    count16();
    check("bounce_led6", cnt[6], 16);
    check("bounce_led7", cnt[7], 8);
    check("bounce_others", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5], 0);

    // Pause with prescaler at 2 for 50 cycles, then resume.
    EN = 1'b1;
    wait_k(10);
    for (int i = 0; i < 20 && m_presc != 2; i++) @(negedge CLK);
    check("pause_presc", m_presc, 2);
    EN = 1'b0;
    repeat (50) @(negedge CLK);
    EN = 1'b1;
    repeat (12) @(negedge CLK);

    // Asynchronous reset between edges while pos=5.
    wait_k(19);
    async_pulse();
    repeat (40) @(negedge CLK);

    // Randomized enable with occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      EN = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) async_pulse();
    end

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
